// File: rtl/rip_pipe_ctrl_if.sv
// Issue-stage metadata in, pipeline control out, for rip_pipe_ctrl.
// master = datapath side, slave = controller side.
interface rip_pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int REG_W  = 5
);
  logic [REG_W-1:0]  ISSUE_RS1;
  logic [REG_W-1:0]  ISSUE_RS2;
  logic              ISSUE_USE1;
  logic              ISSUE_USE2;
  logic [REG_W-1:0]  ISSUE_RD;
  logic              ISSUE_WEN;
  logic              ISSUE_LOAD;
  logic              REDIRECT;
  logic              FREEZE;
  logic [STAGES-1:0] STAGE_VALID;
  logic [STAGES-1:0] STAGE_EN;
  logic              STALL;
  logic              FLUSH;
  logic [STAGES-1:0] FWD1;
  logic [STAGES-1:0] FWD2;
  logic              RETIRE;
  logic [31:0]       STALL_CNT;

  modport master (
    output ISSUE_RS1, ISSUE_RS2, ISSUE_USE1, ISSUE_USE2,
    output ISSUE_RD, ISSUE_WEN, ISSUE_LOAD,
    output REDIRECT, FREEZE,
    input  STAGE_VALID, STAGE_EN, STALL, FLUSH,
    input  FWD1, FWD2, RETIRE, STALL_CNT
  );

  modport slave (
    input  ISSUE_RS1, ISSUE_RS2, ISSUE_USE1, ISSUE_USE2,
    input  ISSUE_RD, ISSUE_WEN, ISSUE_LOAD,
    input  REDIRECT, FREEZE,
    output STAGE_VALID, STAGE_EN, STALL, FLUSH,
    output FWD1, FWD2, RETIRE, STALL_CNT
  );
endinterface

// File: rtl/rip_pipe_ctrl.sv
// N-stage pipeline control: valid tracking, load-use stall, forwarding,
// redirect/freeze priority. Ports: CLK, RST (sync high), pif (slave).
module rip_pipe_ctrl #(
  parameter int STAGES     = 6,
  parameter int REG_W      = 5,
  parameter int ISSUE      = 2,
  parameter int BR_STAGE   = 3,
  parameter int LOAD_STAGE = 5
) (
  input logic            CLK,
  input logic            RST,
  rip_pipe_ctrl_if.slave pif
);

  localparam int M0 = ISSUE + 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [REG_W-1:0]  rd_q [STAGES-1:M0];
  logic [REG_W-1:0]  rd_d [STAGES-1:M0];
  logic [STAGES-1:M0] wen_q, wen_d;
  logic [STAGES-1:M0] load_q, load_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic [STAGES-1:0] oh1, oh2, ldm, en;
  logic              haz, acc_rdr, stall;

  // Nearest producer per source; scanning oldest-first lets the
  // youngest hit overwrite.
  always_comb begin
    oh1 = '0;
    oh2 = '0;
    ldm = '0;
    for (int s = STAGES-1; s > ISSUE; s--) begin
      ldm[s] = load_q[s] & (s < LOAD_STAGE);
      if (valid_q[s] && wen_q[s] &&
          rd_q[s] == pif.ISSUE_RS1 &&
          pif.ISSUE_RS1 != '0) begin
        oh1    = '0;
        oh1[s] = 1'b1;
      end
      if (valid_q[s] && wen_q[s] &&
          rd_q[s] == pif.ISSUE_RS2 &&
          pif.ISSUE_RS2 != '0) begin
        oh2    = '0;
        oh2[s] = 1'b1;
      end
    end
    haz = (pif.ISSUE_USE1 & |(oh1 & ldm)) |
          (pif.ISSUE_USE2 & |(oh2 & ldm));
    acc_rdr = pif.REDIRECT & valid_q[BR_STAGE] &
              ~pif.FREEZE;
    stall = valid_q[ISSUE] & ~pif.FREEZE &
            ~acc_rdr & haz;
  end

  always_comb begin
    valid_d     = valid_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    load_d      = load_q;
    en          = '0;
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    if (!pif.FREEZE) begin
      en         = '1;
      valid_d[0] = 1'b1;
      for (int s = 1; s < STAGES; s++)
        valid_d[s] = valid_q[s-1];
      rd_d[M0]   = pif.ISSUE_RD;
      wen_d[M0]  = pif.ISSUE_WEN;
      load_d[M0] = pif.ISSUE_LOAD;
      for (int s = M0 + 1; s < STAGES; s++) begin
        rd_d[s]   = rd_q[s-1];
        wen_d[s]  = wen_q[s-1];
        load_d[s] = load_q[s-1];
      end
      if (acc_rdr) begin
        for (int s = 1; s <= BR_STAGE; s++)
          valid_d[s] = 1'b0;
      end else if (stall) begin
        // Front holds; a bubble enters just past issue.
        for (int s = 0; s <= ISSUE; s++) begin
          valid_d[s] = valid_q[s];
          en[s]      = 1'b0;
        end
        valid_d[M0] = 1'b0;
        rd_d[M0]    = '0;
        wen_d[M0]   = 1'b0;
        load_d[M0]  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q     <= '0;
      wen_q       <= '0;
      load_q      <= '0;
      stall_cnt_q <= '0;
      for (int s = M0; s < STAGES; s++)
        rd_q[s] <= '0;
    end else begin
      valid_q     <= valid_d;
      wen_q       <= wen_d;
      load_q      <= load_d;
      stall_cnt_q <= stall_cnt_d;
      for (int s = M0; s < STAGES; s++)
        rd_q[s] <= rd_d[s];
    end
  end

  assign pif.STAGE_VALID = valid_q;
  assign pif.STAGE_EN    = RST ? '0 : en;
  assign pif.STALL       = stall;
  assign pif.FLUSH       = acc_rdr;
  assign pif.FWD1 = (pif.ISSUE_USE1 && !stall) ? oh1 : '0;
  assign pif.FWD2 = (pif.ISSUE_USE2 && !stall) ? oh2 : '0;
  assign pif.RETIRE      = valid_q[STAGES-1] & ~pif.FREEZE;
  assign pif.STALL_CNT   = stall_cnt_q;

endmodule

// File: doc/rip_pipe_ctrl.md
# rip_pipe_ctrl

Parametrised pipeline control unit for the rip in-order cores. It tracks per-stage valid bits and destination-register metadata for an N-stage pipeline, detects load-use hazards at the issue stage, selects operand forwarding sources, and applies branch redirects, external freezes and stall bubbles with a fixed priority. It replaces the hand-coded per-stage INVALID/STALL/READY logic. It is instantiated once per core, next to the datapath stage registers, which load when their `STAGE_EN` bit is set.

## Interface

Parameters:
- `STAGES`, default 6: stage count; index 0 = PC, 1 = IF, 2 = DE, 3 = EX, 4 = MA, 5 = WB. Legal range ≥ 4.
- `REG_W`, default 5: register-number width.
- `ISSUE`, default 2: stage where operands are read and hazards are checked.
- `BR_STAGE`, default 3: stage that resolves redirects. Must satisfy ISSUE < BR_STAGE ≤ STAGES−2.
- `LOAD_STAGE`, default 5: first stage whose load result can be forwarded. Must satisfy ISSUE < LOAD_STAGE ≤ STAGES−1.

Ports (name, direction, width, meaning):
- `CLK` in 1: the single clock.
- `RST` in 1: synchronous, active-high reset.
- `ISSUE_RS1`, `ISSUE_RS2` in REG_W: source registers of the instruction at ISSUE.
- `ISSUE_USE1`, `ISSUE_USE2` in 1: the corresponding source is actually read.
- `ISSUE_RD` in REG_W, `ISSUE_WEN` in 1, `ISSUE_LOAD` in 1: destination register, register-write flag and load flag of the ISSUE instruction.
- `REDIRECT` in 1: the instruction at BR_STAGE changes the PC.
- `FREEZE` in 1: global hold, e.g. for a memory wait.
- `STAGE_VALID` out STAGES: bit s = stage s holds a live instruction.
- `STAGE_EN` out STAGES: bit s = stage s register captures from stage s−1 this cycle. Bit 0 = the PC register updates.
- `STALL` out 1: load-use stall is taken this cycle.
- `FLUSH` out 1: redirect is accepted this cycle. The PC source must select the redirect target.
- `FWD1`, `FWD2` out STAGES: one-hot forwarding source for rs1/rs2. All-zero means read the register file.
- `RETIRE` out 1: the last stage commits this cycle.
- `STALL_CNT` out 32: count of cycles in which STALL was taken.

## Operation

- Internal state per stage s > ISSUE: `valid`, `rd`, `wen`, `load`. These are copied from the issue inputs, then shifted along with `valid`.
- **Hazard:** `hit(s, rs)` = valid[s] & wen[s] & rd[s]==rs & rs≠0. The nearest match is the lowest s in ISSUE+1..STAGES−1 with a hit.
- `STALL` = valid[ISSUE] & ¬FREEZE & ¬acc_redirect & (for either used source, the nearest match is a load with s < LOAD_STAGE).
- `FWDn` = one-hot of the nearest match when USEn is set and there is no stall; otherwise all zero. Older matches are never selected.
- `acc_redirect` = REDIRECT & valid[BR_STAGE] & ¬FREEZE. `FLUSH` = acc_redirect. REDIRECT is ignored when valid[BR_STAGE] = 0.
- **Per-cycle update, priority RST > FREEZE > redirect > stall > normal:**
  - RST: all valid and metadata go to 0, and STALL_CNT goes to 0.
  - FREEZE: all state holds and STAGE_EN = 0. The redirect source must hold REDIRECT.
  - Redirect: valid[1..BR_STAGE] ← 0, valid[0] ← 1, and stages > BR_STAGE shift normally. STAGE_EN is all ones.
  - Stall: stages 0..ISSUE hold, with STAGE_EN = 0 for them. valid[ISSUE+1] ← 0 (bubble), and stages > ISSUE+1 shift.
  - Normal: valid[0] ← 1, valid[s] ← valid[s−1], and STAGE_EN is all ones.
- `RETIRE` = valid[STAGES−1] & ¬FREEZE.
- `STALL_CNT` increments on STALL and wraps at 2^32−1 → 0.

## Timing

- Reset values: STAGE_VALID = 0 and STALL_CNT = 0. All other outputs are combinational and are therefore also 0 while the state is reset.
- After RST falls, STAGE_VALID[0] = 1 after one clock. The first instruction reaches stage s after s+1 clocks.
- All outputs are combinational from the registered state plus the current inputs. There is no added latency.
- Load-use stall lasts exactly (LOAD_STAGE − s_load) cycles, where s_load is the load's stage at first detection. With defaults, an adjacent load gives 2 stall cycles.
- Redirect and stall in the same cycle: the redirect wins, STALL = 0, and STALL_CNT does not increment.
- RST asserted mid-operation clears everything at the next edge, regardless of FREEZE.

## Test plan

- Reset release, no hazards: STAGE_VALID goes 000001 → 000011 → … → 111111 in 6 cycles. RETIRE = 1 from cycle 6.
- Issue reads x5, with ALU rd=x5 in stage 3 and rd=x5 in stage 4: FWD1 = 001000 (nearest only), STALL = 0.
- Load rd=x7 in stage 3, issue uses rs2=x7: STALL = 1 for 2 cycles, bubbles appear in stage 3, then FWD2 = 100000. STALL_CNT = 2.
- REDIRECT with valid[3] = 1 while a stall is pending: FLUSH = 1, STALL = 0, and the next STAGE_VALID has bits 1..3 = 0 and bit 0 = 1.
- FREEZE held for 3 cycles mid-stream: STAGE_EN = 0, state unchanged, RETIRE = 0; the pipeline resumes identically afterwards.
- rd = x0 load ahead of a consumer of x0: no stall and FWD = 0. Preload STALL_CNT near 2^32−1 via stalls to confirm it wraps to 0.
